// File: rtl/atm_controller_fsm_pkg.sv
// -----------------------------------------------------------------------------
// atm_controller_fsm_pkg
// Shared definitions for the ATM session controller: the 3-bit state
// encoding seen on the 'state' output and the default authentication limits.
// -----------------------------------------------------------------------------
package atm_controller_fsm_pkg;

   // Default number of PIN_ENTRY cycles without a verdict that count as one
   // failed attempt, and the number of failed attempts that lock the terminal.
   localparam int DEF_PIN_TIMEOUT  = 4;
   localparam int DEF_MAX_ATTEMPTS = 3;

   // Encodings are visible to the display logic, so they are fixed
   // explicitly. Code 7 is unused and recovers to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PIN_ENTRY = 3'd1,
      ST_MENU      = 3'd2,
      ST_BALANCE   = 3'd3,
      ST_WITHDRAW  = 3'd4,
      ST_DISPENSE  = 3'd5,
      ST_FROZEN    = 3'd6
   } state_t;

   // True for states that belong to an authenticated session.
   function automatic logic is_authenticated(input state_t st);
      return (st == ST_MENU) || (st == ST_BALANCE) ||
             (st == ST_WITHDRAW) || (st == ST_DISPENSE);
   endfunction

endpackage

// File: rtl/atm_pin_attempt_ctr.sv
// -----------------------------------------------------------------------------
// atm_pin_attempt_ctr
// Timeout and failed-attempt counters for PIN entry. Every PIN_TIMEOUT cycles
// spent in PIN_ENTRY without correct_pin count as one failed attempt; the
// attempt that reaches MAX_ATTEMPTS raises a single-cycle lockout request.
//
// Ports:
//   clk           in  system clock, rising edge
//   reset         in  asynchronous, active-high reset
//   in_pin_entry  in  controller is currently in PIN_ENTRY
//   clear         in  start of a new session (card accepted in IDLE)
//   correct_pin   in  upstream PIN-verified strobe
//   lockout       out final failed attempt occurs on this edge
// -----------------------------------------------------------------------------
module atm_pin_attempt_ctr
   import atm_controller_fsm_pkg::*;
#(
   parameter int PIN_TIMEOUT  = DEF_PIN_TIMEOUT,
   parameter int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS
) (
   input  logic clk,
   input  logic reset,
   input  logic in_pin_entry,
   input  logic clear,
   input  logic correct_pin,
   output logic lockout
);

   localparam int TW = (PIN_TIMEOUT > 1) ? $clog2(PIN_TIMEOUT) : 1;
   localparam int AW = $clog2(MAX_ATTEMPTS + 1);

   localparam logic [TW-1:0] TMO_LAST = TW'(PIN_TIMEOUT - 1);
   localparam logic [AW-1:0] ATT_LAST = AW'(MAX_ATTEMPTS - 1);
   localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);

   logic [TW-1:0] tmo_cnt;
   logic [AW-1:0] att_cnt;
   logic          timeout_hit;

   // A verdict on the same edge as the timeout cancels the failed attempt.
   assign timeout_hit = in_pin_entry && !correct_pin && (tmo_cnt == TMO_LAST);
   assign lockout     = timeout_hit && (att_cnt == ATT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
         att_cnt <= '0;
      end else if (clear || (in_pin_entry && correct_pin)) begin
         tmo_cnt <= '0;
         att_cnt <= '0;
      end else if (in_pin_entry) begin
         if (timeout_hit) begin
            tmo_cnt <= '0;
            // Saturate rather than wrap.
            if (att_cnt != ATT_MAX) begin
               att_cnt <= att_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/atm_controller_fsm.sv
// -----------------------------------------------------------------------------
// atm_controller_fsm
// Moore control FSM for an ATM session: card insertion, PIN authentication,
// menu, balance enquiry, withdrawal and dispense, with terminal lock after
// repeated failed authentication.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-high reset
//   insert_card     in   card-inserted request
//   pin_input[15:0] in   keyed PIN value (verified upstream; unused here)
//   correct_pin     in   upstream PIN-verified strobe
//   balance_check   in   menu request: balance enquiry
//   withdraw        in   menu request: withdrawal
//   print_balance   in   print-receipt request
//   amount_entered  in   withdrawal amount confirmed
//   cash_eject      in   cash taken / dispenser done
//   exit            in   cancel / end session
//   state[2:0]      out  current state encoding
//   auth_success    out  session authenticated
//   freeze          out  terminal locked
// -----------------------------------------------------------------------------
module atm_controller_fsm
   import atm_controller_fsm_pkg::*;
#(
   parameter int PIN_TIMEOUT  = DEF_PIN_TIMEOUT,
   parameter int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        insert_card,
   input  logic [15:0] pin_input,
   input  logic        correct_pin,
   input  logic        balance_check,
   input  logic        withdraw,
   input  logic        print_balance,
   input  logic        amount_entered,
   input  logic        cash_eject,
   input  logic        exit,
   output logic [2:0]  state,
   output logic        auth_success,
   output logic        freeze
);

   state_t cur_state;
   state_t nxt_state;
   logic   lockout;
   logic   session_start;
   logic   pin_unused;

   // The PIN value is checked upstream; only the verdict matters here.
   assign pin_unused = ^pin_input;

   assign session_start = (cur_state == ST_IDLE) && insert_card;

   atm_pin_attempt_ctr #(
      .PIN_TIMEOUT  (PIN_TIMEOUT),
      .MAX_ATTEMPTS (MAX_ATTEMPTS)
   ) u_attempt_ctr (
      .clk          (clk),
      .reset        (reset),
      .in_pin_entry (cur_state == ST_PIN_ENTRY),
      .clear        (session_start),
      .correct_pin  (correct_pin),
      .lockout      (lockout)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= ST_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state logic. Within each state the if/else chain encodes request
   // priority.
   always_comb begin
      // NOTE: default assignment first so no path leaves nxt_state unassigned
      // (which would infer a latch).
      nxt_state = cur_state;
      case (cur_state)
         ST_IDLE: begin
            if (insert_card) nxt_state = ST_PIN_ENTRY;
         end
         ST_PIN_ENTRY: begin
            // A lockout cannot be dodged by cancelling on the same edge.
            if (correct_pin)  nxt_state = ST_MENU;
            else if (lockout) nxt_state = ST_FROZEN;
            else if (exit)    nxt_state = ST_IDLE;
         end
         ST_MENU: begin
            if (exit)               nxt_state = ST_IDLE;
            else if (withdraw)      nxt_state = ST_WITHDRAW;
            else if (balance_check) nxt_state = ST_BALANCE;
         end
         ST_BALANCE: begin
            if (exit)               nxt_state = ST_IDLE;
            else if (print_balance) nxt_state = ST_MENU;
         end
         ST_WITHDRAW: begin
            if (exit)                nxt_state = ST_IDLE;
            else if (amount_entered) nxt_state = ST_DISPENSE;
         end
         ST_DISPENSE: begin
            if (cash_eject || exit) nxt_state = ST_IDLE;
         end
         ST_FROZEN: begin
            nxt_state = ST_FROZEN;
         end
         default: begin
            nxt_state = ST_IDLE;
         end
      endcase
   end

   // Output decode of the registered state only.
   always_comb begin
      state        = cur_state;
      auth_success = is_authenticated(cur_state);
      freeze       = (cur_state == ST_FROZEN);
   end

endmodule

// File: tb/tb_atm_controller_fsm.sv
// -----------------------------------------------------------------------------
// tb_atm_controller_fsm
// Directed self-checking bench for atm_controller_fsm. Each step pushes the
// expected state/outputs to a scoreboard queue, applies one clock edge and
// compares the popped expectation against the DUT.
// -----------------------------------------------------------------------------
module tb_atm_controller_fsm;

   localparam logic [2:0] S_IDLE = 3'd0, S_PIN = 3'd1, S_MENU = 3'd2,
                          S_BAL = 3'd3, S_WD = 3'd4, S_DISP = 3'd5,
                          S_FROZEN = 3'd6;

   logic        clk = 1'b0;
   logic        reset;
   logic        insert_card, correct_pin, balance_check, withdraw;
   logic        print_balance, amount_entered, cash_eject, exit;
   logic [15:0] pin_input;
   logic [2:0]  state;
   logic        auth_success, freeze;

   typedef struct {
      logic [2:0] st;
      logic       auth;
      logic       frz;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   atm_controller_fsm dut (
      .clk            (clk),
      .reset          (reset),
      .insert_card    (insert_card),
      .pin_input      (pin_input),
      .correct_pin    (correct_pin),
      .balance_check  (balance_check),
      .withdraw       (withdraw),
      .print_balance  (print_balance),
      .amount_entered (amount_entered),
      .cash_eject     (cash_eject),
      .exit           (exit),
      .state          (state),
      .auth_success   (auth_success),
      .freeze         (freeze)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Expected outputs derived from the expected state.
   task automatic push_exp(input logic [2:0] st);
      exp_t e;
      e.st   = st;
      e.auth = (st == S_MENU) || (st == S_BAL) || (st == S_WD) || (st == S_DISP);
      e.frz  = (st == S_FROZEN);
      exp_q.push_back(e);
   endtask

   task automatic sample(input string tag);
      exp_t e;
      total++;
      assert (exp_q.size() > 0) else begin
         bad++;
         $error("FAIL %s: observed=empty_queue expected=entry", tag);
         return;
      end
      total--;
      e = exp_q.pop_front();
      check({tag, ".state"}, {5'd0, state},        {5'd0, e.st});
      check({tag, ".auth"},  {7'd0, auth_success}, {7'd0, e.auth});
      check({tag, ".frz"},   {7'd0, freeze},       {7'd0, e.frz});
   endtask

   task automatic clear_inputs();
      insert_card    = 1'b0;
      correct_pin    = 1'b0;
      balance_check  = 1'b0;
      withdraw       = 1'b0;
      print_balance  = 1'b0;
      amount_entered = 1'b0;
      cash_eject     = 1'b0;
      exit           = 1'b0;
      pin_input      = 16'($urandom);
   endtask

   // Inputs set by the caller are seen at the next rising edge, then cleared.
   task automatic step(input logic [2:0] exp_st, input string tag);
      push_exp(exp_st);
      @(posedge clk);
      #1;
      clear_inputs();
      sample(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      push_exp(S_IDLE);
      sample("reset_async");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      push_exp(S_IDLE);
      sample("in_reset");
      @(negedge clk);
      reset = 1'b0;
      step(S_IDLE, "post_reset");

      // IDLE ignores menu requests.
      balance_check = 1'b1; step(S_IDLE, "idle_bal");
      withdraw      = 1'b1; step(S_IDLE, "idle_wd");

      // Withdraw flow.
      insert_card    = 1'b1; step(S_PIN,  "wd_card");
      step(S_PIN, "wd_pin_wait");
      correct_pin    = 1'b1; step(S_MENU, "wd_pin_ok");
      step(S_MENU, "wd_menu_idle");
      withdraw       = 1'b1; step(S_WD,   "wd_req");
      step(S_WD, "wd_wait");
      amount_entered = 1'b1; step(S_DISP, "wd_amount");
      step(S_DISP, "wd_disp_wait");
      cash_eject     = 1'b1; step(S_IDLE, "wd_eject");

      // Balance flow.
      insert_card   = 1'b1; step(S_PIN,  "bal_card");
      correct_pin   = 1'b1; step(S_MENU, "bal_pin_ok");
      balance_check = 1'b1; step(S_BAL,  "bal_req");
      step(S_BAL, "bal_wait");
      print_balance = 1'b1; step(S_MENU, "bal_print");
      exit          = 1'b1; step(S_IDLE, "bal_exit");

      // Cancel during PIN entry.
      insert_card = 1'b1; step(S_PIN,  "pin_card");
      exit        = 1'b1; step(S_IDLE, "pin_exit");

      // Lockout: 12 cycles in PIN_ENTRY without a verdict.
      insert_card = 1'b1; step(S_PIN, "lk_card");
      for (int i = 0; i < 11; i++) step(S_PIN, "lk_wait");
      step(S_FROZEN, "lk_frozen");
      insert_card = 1'b1; step(S_FROZEN, "lk_card_ign");
      correct_pin = 1'b1; step(S_FROZEN, "lk_pin_ign");
      exit        = 1'b1; step(S_FROZEN, "lk_exit_ign");
      do_reset();
      step(S_IDLE, "lk_after_reset");

      // Near-lockout: verdict on the edge of the third timeout wins.
      insert_card = 1'b1; step(S_PIN, "nl_card");
      for (int i = 0; i < 11; i++) step(S_PIN, "nl_wait");
      correct_pin = 1'b1; step(S_MENU, "nl_pin_ok");
      exit        = 1'b1; step(S_IDLE, "nl_exit");
      // Fresh session must again allow the full 12 cycles.
      insert_card = 1'b1; step(S_PIN, "nl_card2");
      for (int i = 0; i < 11; i++) step(S_PIN, "nl_wait2");
      step(S_FROZEN, "nl_frozen2");
      do_reset();

      // Priorities in MENU.
      insert_card = 1'b1; step(S_PIN,  "pr_card");
      correct_pin = 1'b1; step(S_MENU, "pr_pin_ok");
      withdraw = 1'b1; exit = 1'b1; step(S_IDLE, "pr_exit_over_wd");
      insert_card = 1'b1; step(S_PIN,  "pr_card2");
      correct_pin = 1'b1; step(S_MENU, "pr_pin_ok2");
      withdraw = 1'b1; balance_check = 1'b1; step(S_WD, "pr_wd_over_bal");
      exit = 1'b1; amount_entered = 1'b1; step(S_IDLE, "pr_exit_over_amt");
      insert_card = 1'b1; step(S_PIN,  "pr_card3");
      correct_pin = 1'b1; step(S_MENU, "pr_pin_ok3");
      withdraw       = 1'b1; step(S_WD,   "pr_wd");
      amount_entered = 1'b1; step(S_DISP, "pr_disp");

      // Asynchronous reset between edges while in DISPENSE.
      #2;
      reset = 1'b1;
      #1;
      push_exp(S_IDLE);
      sample("async_reset_disp");
      @(negedge clk);
      reset = 1'b0;
      step(S_IDLE, "after_async");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/atm_controller_fsm.md
Name: atm_controller_fsm

Overview:
- Moore-style control FSM for an ATM session: card insertion, PIN authentication, menu, balance enquiry/print, withdrawal and cash dispense.
- Locks the terminal (freeze) after repeated failed authentication.
- Sits between front-panel/keypad event decoders (single-level request inputs) and the status/display logic.
- PIN verification itself happens upstream; the block consumes only the correct_pin verdict.

Parameters:
- PIN_TIMEOUT, 4: clock cycles in PIN_ENTRY without correct_pin that count as one failed attempt.
- MAX_ATTEMPTS, 3: failed attempts that force FROZEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- insert_card  in  1  card-inserted request.
- pin_input  in  16  keyed PIN value. Reserved; it has no effect on any output.
- correct_pin  in  1  upstream PIN-verified strobe.
- balance_check  in  1  menu request: balance enquiry.
- withdraw  in  1  menu request: withdrawal.
- print_balance  in  1  print-receipt request.
- amount_entered  in  1  withdrawal amount confirmed.
- cash_eject  in  1  cash taken / dispenser done.
- exit  in  1  cancel/end session.
- state  out  3  current state encoding.
- auth_success  out  1  session authenticated.
- freeze  out  1  terminal locked.

Behaviour:
- All inputs are level-sampled at the rising edge of clk. A single high sample is an event.
- State encoding: IDLE=0, PIN_ENTRY=1, MENU=2, BALANCE=3, WITHDRAW=4, DISPENSE=5, FROZEN=6. Code 7 is illegal and recovers to IDLE on the next edge.
- Reset (async, any time, including mid-session):
  - state=IDLE.
  - Attempt counter and timeout counter = 0.
  - auth_success=0, freeze=0.
- IDLE: insert_card -> PIN_ENTRY, and both counters are cleared. All other inputs are ignored.
- PIN_ENTRY:
  - correct_pin -> MENU; counters cleared.
  - Otherwise the timeout counter increments.
  - When the timeout counter reaches PIN_TIMEOUT-1 without correct_pin, the attempt counter increments and the timeout counter clears.
  - When that increment makes the attempt count equal MAX_ATTEMPTS, the next state is FROZEN.
  - correct_pin on the same edge as the final timeout wins (-> MENU).
  - exit -> IDLE, lower priority than correct_pin.
- MENU, priority exit > withdraw > balance_check:
  - exit -> IDLE.
  - withdraw -> WITHDRAW.
  - balance_check -> BALANCE.
  - No request: stay.
- BALANCE, priority exit > print_balance: exit -> IDLE; print_balance -> MENU.
- WITHDRAW, priority exit > amount_entered: exit -> IDLE; amount_entered -> DISPENSE.
- DISPENSE: cash_eject or exit -> IDLE (session ends, card returned).
- FROZEN: absorbing. Only reset leaves it. All inputs, including insert_card, are ignored.
- Outputs are a pure decode of the registered state, so they update in the same cycle as state, with no extra latency:
  - auth_success=1 iff state is MENU, BALANCE, WITHDRAW or DISPENSE.
  - freeze=1 iff state is FROZEN.
- insert_card outside IDLE has no effect. Simultaneous requests resolve by the priorities above.
- Attempt counter width is clog2(MAX_ATTEMPTS+1). Timeout counter width is clog2(PIN_TIMEOUT). Neither counter wraps.

Decomposition:
- Shared package holds:
  - State enum/localparams (3-bit codes above).
  - Default PIN_TIMEOUT and MAX_ATTEMPTS.
- One natural sub-module: atm_pin_attempt_ctr.
  - Contains the timeout and attempt counters.
  - Inputs: clk, reset, in_pin_entry, clear, correct_pin.
  - Output: lockout pulse.
- The FSM next-state and output decode stay in the top module.

Test Plan:
- Reset and idle: assert reset 3 cycles, then release -> state=0, auth_success=0, freeze=0. Toggle balance_check/withdraw in IDLE -> state remains 0.
- Withdraw flow: insert_card, then correct_pin within 2 cycles, then withdraw, amount_entered, cash_eject, one cycle each and spaced -> state 1,2,4,5,0. auth_success=1 in states 2/4/5, then 0 in IDLE.
- Balance flow: insert_card, correct_pin, balance_check, print_balance, exit -> state 1,2,3,2,0. freeze stays 0 throughout.
- Lockout: insert_card, then hold correct_pin=0 with defaults -> FROZEN entered after 12 cycles in PIN_ENTRY. Then freeze=1, state=6, auth_success=0. Later insert_card/correct_pin -> no change. reset -> state=0, freeze=0.
- Near-lockout: correct_pin on the same edge as the 3rd timeout -> state=2 (MENU), not FROZEN. Exit, re-insert card -> attempt count starts from 0 again.
- Priority and mid-session reset:
  - In MENU, assert withdraw and exit together -> IDLE.
  - In MENU, assert withdraw and balance_check together -> WITHDRAW.
  - Async reset asserted between clock edges in DISPENSE -> state=0 immediately, without waiting for an edge.
